password_cracker: RTL and testbench



---
 rtl/password_cracker_pkg.sv | 25 ++
 rtl/password_cracker_base36_digit.sv | 23 ++
 rtl/password_cracker.sv | 69 ++++++
 tb/tb_password_cracker.sv | 111 +++++++++++
 4 files changed

// File: rtl/password_cracker_pkg.sv
// Shared constants, index type and index-to-ASCII mapping for the password cracker.
package password_cracker_pkg;

  localparam int NUM_CHARS  = 4;
  localparam int CHAR_W     = 8;
  localparam int ALPHA_SIZE = 36;
  localparam int IDX_W      = 6;

  typedef logic [IDX_W-1:0] idx_t;

  localparam idx_t MAX_IDX = idx_t'(ALPHA_SIZE - 1);

  // 0..25 -> 'a'..'z', 26..35 -> '0'..'9'; anything else maps to NUL.
  function automatic logic [CHAR_W-1:0] idx_to_ascii(input idx_t idx);
    logic [CHAR_W-1:0] wide;
    wide = CHAR_W'(idx);
    if (idx < idx_t'(26))
      return 8'h61 + wide;
    else if (idx <= MAX_IDX)
      return 8'h30 + wide - 8'd26;
    else
      return '0;
  endfunction

endpackage

// File: rtl/password_cracker_base36_digit.sv
// One mod-36 odometer digit: synchronous load on rst, step on en, carry when wrapping.
module base36_digit
  import password_cracker_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  idx_t load_val,
  input  logic en,
  output idx_t q,
  output logic carry
);

  assign carry = en && (q == MAX_IDX);

  // NOTE: non-blocking assignment so every chained digit updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)
      q <= load_val;
    else if (en)
      q <= (q == MAX_IDX) ? '0 : q + idx_t'(1);
  end

endmodule

// File: rtl/password_cracker.sv
// Brute-force search over the slice of 4-char candidates whose first index lies in [from, to].
// Define FOUND_TRISTATE_EN to drive found as 1/z for wired-OR sharing between instances.
module password_cracker
  import password_cracker_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHARS*CHAR_W-1:0] password_to_crack,
  input  logic [IDX_W-1:0]            from,
  input  logic [IDX_W-1:0]            to,
  output logic                        found,
  output logic                        done
);

  logic [NUM_CHARS*CHAR_W-1:0] target_q;
  logic [NUM_CHARS*CHAR_W-1:0] candidate;
  idx_t                        to_q;
  idx_t                        to_clamped;
  idx_t                        idx0, idx1, idx2, idx3;
  logic                        carry1, carry2, carry3;
  logic                        idx0_wrap_unused;
  logic                        found_q, done_q;
  logic                        empty, hit, last, step;

  assign to_clamped = (to > MAX_IDX) ? MAX_IDX : to;

  assign candidate = {idx_to_ascii(idx0), idx_to_ascii(idx1),
                      idx_to_ascii(idx2), idx_to_ascii(idx3)};

  // idx0 only climbs up to to_q, so idx0 > to_q can only hold for an empty slice.
  assign empty = idx0 > to_q;
  assign hit   = candidate == target_q;
  assign last  = (idx0 == to_q) && (idx1 == MAX_IDX) && (idx2 == MAX_IDX) && (idx3 == MAX_IDX);
  assign step  = !done_q && !empty && !hit && !last;

  base36_digit u_digit3 (.clk(clk), .rst(rst), .load_val('0),  .en(step),   .q(idx3), .carry(carry3));
  base36_digit u_digit2 (.clk(clk), .rst(rst), .load_val('0),  .en(carry3), .q(idx2), .carry(carry2));
  base36_digit u_digit1 (.clk(clk), .rst(rst), .load_val('0),  .en(carry2), .q(idx1), .carry(carry1));
  base36_digit u_digit0 (.clk(clk), .rst(rst), .load_val(from), .en(carry1), .q(idx0),
                         .carry(idx0_wrap_unused));

  // Target and range are captured during reset and ignored afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      target_q <= password_to_crack;
      to_q     <= to_clamped;
      found_q  <= 1'b0;
      done_q   <= 1'b0;
    end else if (!done_q) begin
      if (empty) begin
        done_q <= 1'b1;
      end else if (hit) begin
        found_q <= 1'b1;
        done_q  <= 1'b1;
      end else if (last) begin
        done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;

`ifdef FOUND_TRISTATE_EN
  assign found = found_q ? 1'b1 : 1'bz;
`else
  assign found = found_q;
`endif

endmodule

// File: tb/tb_password_cracker.sv
// Scoreboard bench for password_cracker: expected outcome queued at reset release, compared at done.
module tb_password_cracker;

  typedef struct {
    string tag;
    bit    exp_found;
    int    exp_edges;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] password_to_crack = '0;
  logic [5:0]  from_r = '0;
  logic [5:0]  to_r   = '0;
  logic        found;
  logic        done;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  password_cracker dut (
    .clk(clk),
    .rst(rst),
    .password_to_crack(password_to_crack),
    .from(from_r),
    .to(to_r),
    .found(found),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Reset with the given inputs, then scramble inputs (they must be ignored) and run to done.
  task automatic run_case(input string tag, input logic [31:0] tgt, input logic [5:0] fr,
                          input logic [5:0] t, input bit exp_found, input int exp_edges,
                          input int mid_rst);
    int   edges;
    int   budget;
    exp_t e;
    budget = exp_edges + mid_rst + 16;
    rst = 1'b1;
    password_to_crack = tgt;
    from_r = fr;
    to_r   = t;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_rst_found"}, found, 0);
    check({tag, "_rst_done"}, done, 0);
    rst = 1'b0;
    sb.push_back('{tag, exp_found, exp_edges});
    password_to_crack = ~tgt;
    from_r = ~fr;
    to_r   = ~t;
    edges = 0;
    while (edges < budget) begin
      @(posedge clk);
      #1;
      edges++;
      if (mid_rst > 0 && edges == mid_rst) begin
        check({tag, "_mid_found"}, found, 0);
        rst = 1'b1;
        password_to_crack = tgt;
        from_r = fr;
        to_r   = t;
        @(posedge clk);
        #1;
        rst = 1'b0;
        password_to_crack = ~tgt;
        from_r = ~fr;
        to_r   = ~t;
        edges = 0;
        mid_rst = 0;
      end else if (done === 1'b1) begin
        break;
      end
    end
    e = sb.pop_front();
    check({e.tag, "_done"}, done, 1);
    check({e.tag, "_edges"}, edges, e.exp_edges);
    check({e.tag, "_found"}, found, e.exp_found);
    repeat (3) @(posedge clk);
    #1;
    check({e.tag, "_hold_found"}, found, e.exp_found);
    check({e.tag, "_hold_done"}, done, 1);
  endtask

  initial begin
    // k-th candidate in slice order is compared at edge k+1 after reset release.
    run_case("aaaa",        32'h61616161,  6'd0,  6'd3, 1'b1, 1,     0);
    run_case("aaab",        32'h61616162,  6'd0,  6'd3, 1'b1, 2,     0);
    run_case("aab0",        32'h6161624A - 32'h1A, 6'd0, 6'd3, 1'b1, 63, 0);
    run_case("ea09",        32'h65613039,  6'd4,  6'd7, 1'b1, 972,   0);
    run_case("9aaa_edge",   32'h39616161,  6'd35, 6'd35, 1'b1, 1,    0);
    run_case("from_gt_to",  32'h61616161,  6'd5,  6'd4, 1'b0, 1,     0);
    run_case("from_gt_35",  32'h61616161,  6'd40, 6'd50, 1'b0, 1,    0);
    run_case("abaa_midrst", 32'h61626161,  6'd0,  6'd3, 1'b1, 1297,  100);
    run_case("invalid_AAAA", 32'h41414141, 6'd35, 6'd60, 1'b0, 46656, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
